// File: rtl/leb128_decoder_pkg.sv
// Shared definitions for the LEB128 immediate decoder: FSM state encodings,
// error codes and the maximum encoded lengths for i32/i64 operands.
package leb128_decoder_pkg;

    typedef enum logic [1:0] {
        LEB_IDLE  = 2'd0,
        LEB_ACCUM = 2'd1,
        LEB_DONE  = 2'd2
    } leb_state_e;

    localparam logic [1:0] LEB_OK          = 2'd0;
    localparam logic [1:0] LEB_TOO_LONG    = 2'd1;
    localparam logic [1:0] LEB_UNUSED_BITS = 2'd2;

    localparam logic [3:0] LEB_MAX32 = 4'd5;
    localparam logic [3:0] LEB_MAX64 = 4'd10;

    // Maximum number of encoded bytes for the selected result width.
    function automatic logic [3:0] leb_max_len(input logic is_64);
        return is_64 ? LEB_MAX64 : LEB_MAX32;
    endfunction

endpackage

// File: rtl/leb128_decoder_if.sv
// Byte-in / value-out handshake bundle between the cpu fetch/execute stages
// (master) and the LEB128 decoder (slave).
interface leb128_decoder_if;

    logic        start;
    logic        is_signed;
    logic        is_64;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic [1:0]  out_err;

    modport master (
        output start, is_signed, is_64, in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_value, out_len, out_err
    );

    modport slave (
        input  start, is_signed, is_64, in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_value, out_len, out_err
    );

endinterface

// File: rtl/leb128_decoder.sv
// LEB128 decoder for WebAssembly immediates (ULEB/SLEB, i32/i64).
// Bytes are accumulated 7 bits at a time; the terminating byte triggers
// sign extension, width masking and a registered result held until popped.
// Optional build macro LEB128_STRICT_EN: reject set unused bits in the final
// max-length byte with error code LEB_UNUSED_BITS; otherwise they are dropped.
module leb128_decoder
    import leb128_decoder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    leb128_decoder_if.slave    bus
);

    leb_state_e  state_q, state_d;
    logic        is_signed_q, is_signed_d;
    logic        is_64_q, is_64_d;
    logic [63:0] acc_q, acc_d;
    logic [3:0]  count_q, count_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] value_q, value_d;
    logic [3:0]  len_q, len_d;
    logic [1:0]  err_q, err_d;

    logic [7:0]  in_byte;
    logic [6:0]  shamt;
    logic [6:0]  sign_pos;
    logic [63:0] shifted;
    logic [63:0] acc_next;
    logic [63:0] ext_mask;
    logic [63:0] fin_value;
    logic [3:0]  count_next;
    logic        at_max;
    logic        strict_viol;

    assign in_byte = bus.in_byte;

`ifdef LEB128_STRICT_EN
    // Unused high bits of the last permitted byte must be zero (unsigned)
    // or copies of the sign bit (signed).
    function automatic logic unused_bits_bad(input logic [6:0] b,
                                             input logic sgn,
                                             input logic wide);
        logic bad;
        if (wide) begin
            bad = sgn ? !((b == 7'h00) || (b == 7'h7F)) : (b[6:1] != 6'd0);
        end else begin
            bad = sgn ? !((b[6:3] == 4'h0) || (b[6:3] == 4'hF)) : (b[6:4] != 3'd0);
        end
        return bad;
    endfunction
`endif

    // Next-state, accumulator and result computation.
    always_comb begin
        state_d     = state_q;
        is_signed_d = is_signed_q;
        is_64_d     = is_64_q;
        acc_d       = acc_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        value_d     = value_q;
        len_d       = len_q;
        err_d       = err_q;

        // Payload bits placed at 7*count; positions at or beyond 64 drop out.
        shamt      = {3'd0, count_q} * 7'd7;
        shifted    = (shamt < 7'd64) ? (64'(in_byte[6:0]) << shamt) : 64'd0;
        acc_next   = acc_q | shifted;
        count_next = count_q + 4'd1;

        // Sign bit of the final byte sits at 7*count+6; fill everything above it.
        sign_pos  = shamt + 7'd6;
        ext_mask  = (sign_pos < 7'd63) ? ~((64'd1 << (sign_pos + 7'd1)) - 64'd1) : 64'd0;
        fin_value = (is_signed_q && in_byte[6]) ? (acc_next | ext_mask) : acc_next;
        if (!is_64_q) begin
            fin_value = {32'd0, fin_value[31:0]};
        end

        at_max = (count_next == leb_max_len(is_64_q));
`ifdef LEB128_STRICT_EN
        strict_viol = unused_bits_bad(in_byte[6:0], is_signed_q, is_64_q);
`else
        strict_viol = 1'b0;
`endif

        case (state_q)
            LEB_IDLE: begin
                if (bus.start) begin
                    is_signed_d = bus.is_signed;
                    is_64_d     = bus.is_64;
                    acc_d       = 64'd0;
                    count_d     = 4'd0;
                    in_ready_d  = 1'b1;
                    state_d     = LEB_ACCUM;
                end
            end
            LEB_ACCUM: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_d   = acc_next;
                    count_d = count_next;
                    if (!in_byte[7]) begin
                        state_d     = LEB_DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        len_d       = count_next;
                        if (at_max && strict_viol) begin
                            err_d   = LEB_UNUSED_BITS;
                            value_d = 64'd0;
                        end else begin
                            err_d   = LEB_OK;
                            value_d = fin_value;
                        end
                    end else if (at_max) begin
                        // Continuation bit still set on the last legal byte.
                        state_d     = LEB_DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        len_d       = count_next;
                        err_d       = LEB_TOO_LONG;
                        value_d     = 64'd0;
                    end
                end
            end
            LEB_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = LEB_IDLE;
                end
            end
            default: begin
                state_d     = LEB_IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any partial decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LEB_IDLE;
            is_signed_q <= 1'b0;
            is_64_q     <= 1'b0;
            acc_q       <= 64'd0;
            count_q     <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            value_q     <= 64'd0;
            len_q       <= 4'd0;
            err_q       <= LEB_OK;
        end else begin
            state_q     <= state_d;
            is_signed_q <= is_signed_d;
            is_64_q     <= is_64_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            value_q     <= value_d;
            len_q       <= len_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = value_q;
    assign bus.out_len   = len_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed testbench for leb128_decoder. Expected results are hand-decoded
// LEB128 vectors; the LEB128_STRICT_EN build changes only the unused-bits case.
module tb_leb128_decoder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    leb128_decoder_if bus();

    leb128_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_decode(input logic s, input logic w);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.is_64     = w;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic feed(input logic s, input logic w, input logic [79:0] bytes, input int n);
        start_decode(s, w);
        for (int i = 0; i < n; i++) begin
            push(bytes[8*i +: 8]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_value !== 64'd0) begin errors++; $display("FAIL reset_out_value got %h exp 0", bus.out_value); end
        checks++; if (bus.out_len !== 4'd0) begin errors++; $display("FAIL reset_out_len got %0d exp 0", bus.out_len); end
        checks++; if (bus.out_err !== 2'd0) begin errors++; $display("FAIL reset_out_err got %0d exp 0", bus.out_err); end
    endtask

    task automatic test_uleb_single();
        start_decode(1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL u1_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL u1_early_valid got %b exp 0", bus.out_valid); end
        push(8'h01);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL u1_out_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_value !== 64'd1) begin errors++; $display("FAIL u1_value got %h exp 1", bus.out_value); end
        checks++; if (bus.out_len !== 4'd1) begin errors++; $display("FAIL u1_len got %0d exp 1", bus.out_len); end
        checks++; if (bus.out_err !== 2'd0) begin errors++; $display("FAIL u1_err got %0d exp 0", bus.out_err); end
        pop();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL u1_after_pop got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_sleb_sign();
        feed(1'b1, 1'b0, 80'h7F, 1);
        checks++; if (bus.out_value !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL s32_m1_value got %h exp 00000000ffffffff", bus.out_value); end
        checks++; if (bus.out_len !== 4'd1) begin errors++; $display("FAIL s32_m1_len got %0d exp 1", bus.out_len); end
        pop();
        feed(1'b1, 1'b1, 80'h7F80, 2);
        checks++; if (bus.out_value !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL s64_m128_value got %h exp ffffffffffffff80", bus.out_value); end
        checks++; if (bus.out_len !== 4'd2) begin errors++; $display("FAIL s64_m128_len got %0d exp 2", bus.out_len); end
        pop();
        // Ten-byte i64 -1: last byte places its single payload bit at 63.
        feed(1'b1, 1'b1, 80'h7F_FF_FF_FF_FF_FF_FF_FF_FF_FF, 10);
        checks++; if (bus.out_value !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL s64_max_value got %h exp ffffffffffffffff", bus.out_value); end
        checks++; if (bus.out_len !== 4'd10 || bus.out_err !== 2'd0) begin errors++; $display("FAIL s64_max_len_err got %0d/%0d exp 10/0", bus.out_len, bus.out_err); end
        pop();
        feed(1'b0, 1'b1, 80'h01_80_80_80_80_80_80_80_80_80, 10);
        checks++; if (bus.out_value !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL u64_top_value got %h exp 8000000000000000", bus.out_value); end
        pop();
    endtask

    task automatic test_hold();
        feed(1'b0, 1'b0, 80'h268EE5, 3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_value !== 64'h98765 || bus.out_len !== 4'd3 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got v=%b val=%h len=%0d rdy=%b exp 1/98765/3/0", i, bus.out_valid, bus.out_value, bus.out_len, bus.in_ready);
            end
            tick();
        end
        pop();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_after_pop got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_too_long();
        feed(1'b0, 1'b0, 80'h80_80_80_80_80, 5);
        checks++; if (bus.out_err !== 2'd1) begin errors++; $display("FAIL long_err got %0d exp 1", bus.out_err); end
        checks++; if (bus.out_len !== 4'd5) begin errors++; $display("FAIL long_len got %0d exp 5", bus.out_len); end
        checks++; if (bus.out_value !== 64'd0) begin errors++; $display("FAIL long_value got %h exp 0", bus.out_value); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL long_in_ready got %b exp 0", bus.in_ready); end
        push(8'h01);
        checks++; if (bus.out_len !== 4'd5 || bus.out_err !== 2'd1) begin errors++; $display("FAIL long_6th_byte got len=%0d err=%0d exp 5/1", bus.out_len, bus.out_err); end
        pop();
    endtask

    task automatic test_unused_bits();
        feed(1'b0, 1'b0, 80'h1F_FF_FF_FF_FF, 5);
`ifdef LEB128_STRICT_EN
        checks++; if (bus.out_err !== 2'd2) begin errors++; $display("FAIL unused_err got %0d exp 2", bus.out_err); end
        checks++; if (bus.out_value !== 64'd0) begin errors++; $display("FAIL unused_value got %h exp 0", bus.out_value); end
`else
        checks++; if (bus.out_err !== 2'd0) begin errors++; $display("FAIL unused_err got %0d exp 0", bus.out_err); end
        checks++; if (bus.out_value !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL unused_value got %h exp 00000000ffffffff", bus.out_value); end
`endif
        checks++; if (bus.out_len !== 4'd5) begin errors++; $display("FAIL unused_len got %0d exp 5", bus.out_len); end
        pop();
    endtask

    task automatic test_start_on_pop();
        feed(1'b0, 1'b0, 80'h02, 1);
        bus.start = 1'b1;
        pop();
        bus.start = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL start_on_pop_in_ready got %b exp 0", bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        start_decode(1'b0, 1'b0);
        push(8'hE5);
        push(8'h8E);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready got %b exp 0", bus.in_ready); end
        push(8'h26);
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b exp 0", bus.out_valid); end
        feed(1'b0, 1'b0, 80'h05, 1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_value !== 64'd5) begin errors++; $display("FAIL mid_reset_fresh got v=%b val=%h exp 1/5", bus.out_valid, bus.out_value); end
        pop();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.is_64     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        test_reset();
        test_uleb_single();
        test_sleb_sign();
        test_hold();
        test_too_long();
        test_unused_bits();
        test_start_on_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
